// File: rtl/shift_reg_universal.sv
// Universal shift register: shift left/right, parallel load, sync clear, clock enable, word-done strobe.
// Define SHIFT_REG_ROTATE_EN to enable the rotate modes (100/101); otherwise they behave as hold.
module shift_reg_universal #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                           C,
    input  logic                           CLR,
    input  logic                           CE,
    input  logic [2:0]                     MODE,
    input  logic                           SIL,
    input  logic                           SIR,
    input  logic [WIDTH-1:0]               D,
    output logic [WIDTH-1:0]               Q,
    output logic                           SO_MSB,
    output logic                           SO_LSB,
    output logic [$clog2(WIDTH+1)-1:0]     CNT,
    output logic                           DONE
);

    localparam int CNT_W = $clog2(WIDTH+1);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             step;

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        step   = 1'b0;
        if (CE) begin
            case (mode_e'(MODE))
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], SIL};
                    step = 1'b1;
                end
                MODE_SHR: begin
                    q_d  = {SIR, q_q[WIDTH-1:1]};
                    step = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = D;
                    cnt_d = '0;
                end
`ifdef SHIFT_REG_ROTATE_EN
                MODE_ROTL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    step = 1'b1;
                end
                MODE_ROTR: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    step = 1'b1;
                end
`endif
                MODE_CLEAR: begin
                    q_d   = RESET_VALUE;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end

        // The WIDTH-th operation wraps the count and raises DONE instead of reaching WIDTH.
        if (step) begin
            if (cnt_q == CNT_W'(WIDTH-1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            q_q    <= RESET_VALUE;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign Q      = q_q;
    assign CNT    = cnt_q;
    assign DONE   = done_q;
    assign SO_MSB = q_q[WIDTH-1];
    assign SO_LSB = q_q[0];

endmodule
